// File: rtl/cmp_sort_sequencer.sv
// cmp_sort_sequencer: buffers up to DEPTH unsigned bytes from a valid/ready
// load stream, bubble-sorts them in place using a single ripple magnitude
// comparator, then streams them out on a valid/ready unload stream.
// Optional build macro: CMP_SORT_DESCENDING_EN. When it is defined, a pair
// swaps when the comparator reports l, so the output is descending. When it
// is undefined, a pair swaps on g, so the output is ascending.

// 8-bit ripple magnitude comparator, MSB first.
module cmp_mag8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       l_out,
    output logic       e_out,
    output logic       g_out
);
    // Ripple from the MSB down. The first differing bit decides the result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        l_out = 1'b0;
        g_out = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (!l_out && !g_out) begin
                if (a[k] && !b[k])      g_out = 1'b1;
                else if (!a[k] && b[k]) l_out = 1'b1;
            end
        end
        e_out = !l_out && !g_out;
    end
endmodule

module cmp_sort_sequencer #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [2**AW];
    logic [CW-1:0] idx, idx_nx, pass_cnt, rd_ptr, count_final;
    logic          swapped;
    logic          accept, do_swap, last_cmp, pass_last;
    logic [7:0]    cmp_a, cmp_b;
    logic          l_out, e_out, g_out;

    // The single comparator: it always looks at the adjacent pair at idx.
    assign idx_nx = idx + CW'(1);
    assign cmp_a  = mem[idx[AW-1:0]];
    assign cmp_b  = mem[idx_nx[AW-1:0]];

    cmp_mag8 u_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .l_out (l_out),
        .e_out (e_out),
        .g_out (g_out)
    );

    // Swap decision. Equal values never swap, which keeps the sort stable.
`ifdef CMP_SORT_DESCENDING_EN
    assign do_swap = (state == SORT) && !e_out && l_out;
`else
    assign do_swap = (state == SORT) && !e_out && g_out;
`endif

    assign accept      = (state == LOAD) && in_valid && in_ready;
    assign count_final = count + CW'(accept);
    assign last_cmp    = (idx == count - CW'(2));
    assign pass_last   = (pass_cnt == count - CW'(2));
    assign out_data    = out_valid ? mem[rd_ptr[AW-1:0]] : 8'd0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != LOAD);
        unique case (state)
            LOAD: begin
                in_ready = (count < CW'(DEPTH));
                if (start) begin
                    // A beat accepted together with start is part of the sort.
                    state_next = (count_final >= CW'(2)) ? SORT : UNLOAD;
                end
            end
            SORT: begin
                // Stop after a clean pass, or once count-1 passes have run.
                if (last_cmp && (!(swapped || do_swap) || pass_last))
                    state_next = UNLOAD;
            end
            UNLOAD: begin
                out_valid = (count != '0);
                if (count == '0)
                    state_next = LOAD;
                else if (out_ready && (rd_ptr == count - CW'(1)))
                    state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // Counters, pointers, pass bookkeeping and the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            idx      <= '0;
            pass_cnt <= '0;
            swapped  <= 1'b0;
            rd_ptr   <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state != UNLOAD) && (state_next == UNLOAD);
            unique case (state)
                LOAD: begin
                    if (accept) count <= count + CW'(1);
                    idx      <= '0;
                    pass_cnt <= '0;
                    swapped  <= 1'b0;
                    rd_ptr   <= '0;
                end
                SORT: begin
                    if (last_cmp) begin
                        idx      <= '0;
                        swapped  <= 1'b0;
                        pass_cnt <= pass_cnt + CW'(1);
                    end else begin
                        idx <= idx_nx;
                        if (do_swap) swapped <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (state_next == LOAD) begin
                        count  <= '0;
                        rd_ptr <= '0;
                    end else if (out_valid && out_ready) begin
                        rd_ptr <= rd_ptr + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer storage: load writes and in-place swaps.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are meaningless until loaded.
        if (accept) mem[count[AW-1:0]] <= in_data;
        if (do_swap) begin
            mem[idx[AW-1:0]]    <= cmp_b;
            mem[idx_nx[AW-1:0]] <= cmp_a;
        end
    end
endmodule

// File: tb/tb_cmp_sort_sequencer.sv
// Directed self-checking bench for cmp_sort_sequencer (DEPTH=8, CW=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cmp_sort_sequencer;
    typedef logic [7:0] vec_t [8];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    cmp_sort_sequencer #(.DEPTH(8), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic load_beat(input logic [7:0] v, input logic with_start);
        in_valid = 1'b1;
        in_data  = v;
        start    = with_start;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_count"},     count, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data, 0);
    endtask

    // Called on the first falling edge after start was taken.
    task automatic wait_done(input string tag, input int exp_cycles);
        int cyc = 0;
        while (!done && cyc < 300) begin
            check({tag, "_busy_in_sort"}, busy, 1);
            cyc++;
            @(negedge clk);
        end
        check({tag, "_sort_cycles"}, cyc, exp_cycles);
        check({tag, "_done"}, done, 1);
    endtask

    task automatic unload(input string tag, input vec_t exp, input int n);
        out_ready = 1'b1;
        if (n == 0) begin
            check({tag, "_no_valid"}, out_valid, 0);
            @(negedge clk);
        end
        for (int k = 0; k < n; k++) begin
            check({tag, "_out_valid"}, out_valid, 1);
            check($sformatf("%s_out%0d", tag, k), out_data, exp[k]);
            @(negedge clk);
            if (k == 0) check({tag, "_done_one_cycle"}, done, 0);
        end
        out_ready = 1'b0;
        check_idle({tag, "_after"});
    endtask

    vec_t e_a, e_b, e_c, e_d, e_one;
    int   cyc_a, cyc_b, cyc_d;

    initial begin
`ifdef CMP_SORT_DESCENDING_EN
        e_a = '{9, 7, 3, 1, 0, 0, 0, 0};        cyc_a = 6;
        e_b = '{4, 3, 2, 1, 0, 0, 0, 0};        cyc_b = 9;
        e_d = '{255, 200, 128, 99, 17, 17, 1, 0}; cyc_d = 35;
`else
        e_a = '{1, 3, 7, 9, 0, 0, 0, 0};        cyc_a = 9;
        e_b = '{1, 2, 3, 4, 0, 0, 0, 0};        cyc_b = 3;
        e_d = '{0, 1, 17, 17, 99, 128, 200, 255}; cyc_d = 42;
`endif
        e_c   = '{5, 5, 5, 0, 0, 0, 0, 0};
        e_one = '{42, 0, 0, 0, 0, 0, 0, 0};

        // Reset state.
        @(negedge clk);
        check("rst_done", done, 0);
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 9,3,7,1: worst-case pass count.
        load_beat(9, 0); load_beat(3, 0); load_beat(7, 0); load_beat(1, 0);
        check("a_count", count, 4);
        kick();
        wait_done("a", cyc_a);
        unload("a", e_a, 4);

        // 1,2,3,4: already in order.
        load_beat(1, 0); load_beat(2, 0); load_beat(3, 0); load_beat(4, 0);
        kick();
        wait_done("b", cyc_b);
        unload("b", e_b, 4);

        // 5,5,5 with the last beat arriving together with start.
        load_beat(5, 0); load_beat(5, 0); load_beat(5, 1);
        wait_done("c", 2);
        unload("c", e_c, 3);

        // Fill with in_valid held high, then a 9th beat while full.
        begin
            vec_t fill;
            fill = '{200, 0, 255, 17, 17, 128, 1, 99};
            in_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                check($sformatf("d_ready%0d", k), in_ready, 1);
                in_data = fill[k];
                @(negedge clk);
            end
            check("d_full_ready", in_ready, 0);
            check("d_full_count", count, 8);
            in_data = 8'd77;
            @(negedge clk);
            check("d_no_overflow", count, 8);
            in_valid = 1'b0;
        end
        kick();
        wait_done("d", cyc_d);
        unload("d", e_d, 8);

        // Single entry: no sort, done still pulses.
        load_beat(42, 0);
        kick();
        wait_done("one", 0);
        unload("one", e_one, 1);

        // Empty: done pulses, nothing is offered.
        kick();
        wait_done("zero", 0);
        unload("zero", e_one, 0);

        // Reset in the middle of SORT.
        load_beat(9, 0); load_beat(3, 0); load_beat(7, 0); load_beat(1, 0);
        kick();
        @(negedge clk); @(negedge clk);
        check("rs_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rs_done", done, 0);
        check_idle("rs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unload with back-pressure, then reset in the middle of UNLOAD.
        load_beat(9, 0); load_beat(3, 0); load_beat(7, 0); load_beat(1, 0);
        kick();
        wait_done("ru", cyc_a);
        out_ready = 1'b1;
        check("ru_out0", out_data, e_a[0]);
        @(negedge clk);
        out_ready = 1'b0;
        check("ru_out1", out_data, e_a[1]);
        @(negedge clk);
        check("ru_hold1", out_data, e_a[1]);
        check("ru_hold_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        check("ru_hold2", out_data, e_a[1]);
        @(negedge clk);
        check("ru_out2", out_data, e_a[2]);
        rst_n = 1'b0;
        #1;
        check("ru_done", done, 0);
        check_idle("ru");
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("ru_release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
